// File: rtl/aq_dtu_cdc_pulse_rx.sv
// Multi-channel receive side for toggle-encoded pulse events entering dst_clk.
// Each channel synchronises its toggle line, counts edges into a saturating queue and hands them out over valid/ready.
module aq_dtu_cdc_pulse_rx #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 3
) (
    input  logic             dst_clk,
    input  logic             dst_rstn,
    input  logic [NCH-1:0]   src_tgl,
    input  logic [NCH-1:0]   dst_pulse_rdy,
    input  logic [NCH-1:0]   dst_ovf_clr,
    output logic [NCH-1:0]   dst_pulse_vld,
    output logic             dst_any_vld,
    output logic [NCH-1:0]   dst_ack_tgl,
    output logic [NCH-1:0]   dst_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   ack_q;
        logic                   ack_d;
        logic                   ovf_q;
        logic                   ovf_d;
        logic                   evt;
        logic                   pop;
        logic                   drop;

        always_ff @(posedge dst_clk or negedge dst_rstn) begin
            if (!dst_rstn) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], src_tgl[c]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign evt = sync_q[SYNC_STAGES-1] ^ prev_q;
        assign pop = (cnt_q != '0) & dst_pulse_rdy[c];

        // An arriving event and a pop in the same cycle cancel, so a full queue never overflows then.
        always_comb begin
            cnt_d = cnt_q;
            drop  = 1'b0;
            if (evt && !pop) begin
                if (cnt_q == CNT_MAX) begin
                    drop = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (!evt && pop) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        assign ack_d = ack_q ^ pop;
        assign ovf_d = drop | (ovf_q & ~dst_ovf_clr[c]);

        always_ff @(posedge dst_clk or negedge dst_rstn) begin
            if (!dst_rstn) begin
                cnt_q <= '0;
                ack_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ack_q <= ack_d;
                ovf_q <= ovf_d;
            end
        end

        assign dst_pulse_vld[c] = (cnt_q != '0);
        assign dst_ack_tgl[c]   = ack_q;
        assign dst_ovf[c]       = ovf_q;
    end

    assign dst_any_vld = |dst_pulse_vld;

endmodule

// File: tb/tb_aq_dtu_cdc_pulse_rx.sv
// Bench for aq_dtu_cdc_pulse_rx: directed scenarios plus random traffic against an event-count reference model.
module tb_aq_dtu_cdc_pulse_rx;

    localparam int NCH  = 4;
    localparam int S    = 3;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic           dst_clk = 1'b0;
    logic           dst_rstn = 1'b0;
    logic [NCH-1:0] src_tgl = '0;
    logic [NCH-1:0] rdy = '0;
    logic [NCH-1:0] clr = '0;
    logic [NCH-1:0] dst_pulse_vld;
    logic           dst_any_vld;
    logic [NCH-1:0] dst_ack_tgl;
    logic [NCH-1:0] dst_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: queued-event count per channel, ack parity, sticky overflow,
    // and the line values captured at each edge (an event is seen S edges after capture).
    int             mcnt[NCH];
    logic [NCH-1:0] mack;
    logic [NCH-1:0] movf;
    logic [NCH-1:0] hist[$];
    int             last[NCH];

    aq_dtu_cdc_pulse_rx #(.NCH(NCH), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .dst_clk       (dst_clk),
        .dst_rstn      (dst_rstn),
        .src_tgl       (src_tgl),
        .dst_pulse_rdy (rdy),
        .dst_ovf_clr   (clr),
        .dst_pulse_vld (dst_pulse_vld),
        .dst_any_vld   (dst_any_vld),
        .dst_ack_tgl   (dst_ack_tgl),
        .dst_ovf       (dst_ovf)
    );

    always #5 dst_clk = ~dst_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) mcnt[c] = 0;
        mack = '0;
        movf = '0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
    endfunction

    function automatic void model_edge();
        logic [NCH-1:0] e;
        if (!dst_rstn) begin
            model_reset();
            return;
        end
        e = hist[0] ^ hist[1];
        for (int c = 0; c < NCH; c++) begin
            bit p;
            bit drop;
            p    = (mcnt[c] > 0) && rdy[c];
            drop = 1'b0;
            if (e[c] && !p) begin
                if (mcnt[c] == MAXC) drop = 1'b1;
                else mcnt[c]++;
            end else if (!e[c] && p) begin
                mcnt[c]--;
            end
            if (p) mack[c] = ~mack[c];
            if (drop) movf[c] = 1'b1;
            else if (clr[c]) movf[c] = 1'b0;
        end
        void'(hist.pop_front());
        hist.push_back(src_tgl);
    endfunction

    function automatic logic [NCH-1:0] model_vld();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (mcnt[c] != 0);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [NCH-1:0] ev;
        @(posedge dst_clk);
        model_edge();
        #1;
        ev = model_vld();
        chk("vld", dst_pulse_vld, ev);
        chk("any_vld", 4'(dst_any_vld), 4'(|ev));
        chk("ack_tgl", dst_ack_tgl, mack);
        chk("ovf", dst_ovf, movf);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] r);
        rdy = r;
        clr = '0;
        repeat (n) step();
    endtask

    // One source toggle followed by the S+1 cycles the contract requires; the fourth
    // cycle is the one in which the event reaches the counter.
    task automatic tog(input logic [NCH-1:0] m, input logic [NCH-1:0] r_base,
                       input logic [NCH-1:0] r_edge, input logic [NCH-1:0] c_edge);
        src_tgl ^= m;
        for (int i = 0; i < S + 1; i++) begin
            rdy = (i == S) ? r_edge : r_base;
            clr = (i == S) ? c_edge : '0;
            step();
        end
        rdy = r_base;
        clr = '0;
    endtask

    initial begin
        logic [NCH-1:0] m;
        model_reset();

        // Reset state
        repeat (2) @(posedge dst_clk);
        #1;
        chk("rst_vld", dst_pulse_vld, 4'b0000);
        chk("rst_any", 4'(dst_any_vld), 4'b0000);
        chk("rst_ack", dst_ack_tgl, 4'b0000);
        chk("rst_ovf", dst_ovf, 4'b0000);
        #2 dst_rstn = 1'b1;

        // Single event on ch0
        tog(4'b0001, 4'b1111, 4'b1111, 4'b0000);
        chk("single_vld", dst_pulse_vld, 4'b0001);
        step();
        chk("single_drop", dst_pulse_vld, 4'b0000);
        chk("single_ack", dst_ack_tgl, 4'b0001);

        // Burst of five on ch1 with consumer stalled
        repeat (5) tog(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        chk("burst_vld", dst_pulse_vld, 4'b0010);
        idle(5, 4'b1111);
        chk("burst_drained", dst_pulse_vld, 4'b0000);
        chk("burst_ack", dst_ack_tgl, 4'b0011);

        // Saturation on ch2
        repeat (9) tog(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        chk("sat_ovf", dst_ovf, 4'b0100);
        idle(7, 4'b1111);
        chk("sat_drained", dst_pulse_vld, 4'b0000);
        chk("sat_ack", dst_ack_tgl, 4'b0111);
        rdy = '0;
        clr = 4'b0100;
        step();
        clr = '0;
        chk("sat_clr", dst_ovf, 4'b0000);
        repeat (7) tog(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        tog(4'b0100, 4'b0000, 4'b0000, 4'b0100);
        chk("sat_set_wins", dst_ovf, 4'b0100);
        clr = 4'b0100;
        step();
        idle(7, 4'b1111);
        chk("sat_ack2", dst_ack_tgl, 4'b0011);

        // Edge and pop together on a full ch3
        repeat (7) tog(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        tog(4'b1000, 4'b0000, 4'b1000, 4'b0000);
        chk("edgepop_ovf", dst_ovf, 4'b0000);
        chk("edgepop_ack", 4'(dst_ack_tgl[3]), 4'b0001);
        chk("edgepop_vld", dst_pulse_vld, 4'b1000);
        idle(8, 4'b1111);

        // All channels at once, half of them ready
        tog(4'b1111, 4'b1010, 4'b1010, 4'b0000);
        chk("indep_all", dst_pulse_vld, 4'b1111);
        step();
        chk("indep_half", dst_pulse_vld, 4'b0101);
        chk("indep_any", 4'(dst_any_vld), 4'b0001);
        idle(1, 4'b1111);
        chk("indep_none", 4'(dst_any_vld), 4'b0000);

        // Random traffic within the source contract
        for (int c = 0; c < NCH; c++) last[c] = cyc;
        for (int k = 0; k < 400; k++) begin
            m = '0;
            for (int c = 0; c < NCH; c++) begin
                if ((cyc - last[c] >= S + 1) && ($urandom_range(2) == 0)) begin
                    m[c]    = 1'b1;
                    last[c] = cyc;
                end
            end
            src_tgl ^= m;
            rdy = (k < 200) ? (4'($urandom) & 4'($urandom) & 4'($urandom)) : 4'($urandom);
            clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end
        idle(S + 1, '0);
        idle(8, 4'b1111);

        // Reset in mid-operation with ch0 holding three events and its line at 1
        m = src_tgl;
        if (m != '0) tog(m, 4'b1111, 4'b1111, 4'b0000);
        idle(8, 4'b1111);
        repeat (3) tog(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        chk("mid_pending", dst_pulse_vld, 4'b0001);
        #3 dst_rstn = 1'b0;
        #1;
        model_reset();
        chk("async_vld", dst_pulse_vld, 4'b0000);
        chk("async_ack", dst_ack_tgl, 4'b0000);
        chk("async_ovf", dst_ovf, 4'b0000);
        step();
        step();
        #2 dst_rstn = 1'b1;
        rdy = '0;
        repeat (S) step();
        chk("spur_early", dst_pulse_vld, 4'b0000);
        step();
        chk("spur_event", dst_pulse_vld, 4'b0001);
        idle(2, 4'b1111);

        // Line driven low during reset: nothing follows
        #3 dst_rstn = 1'b0;
        src_tgl = '0;
        #1;
        model_reset();
        step();
        step();
        #2 dst_rstn = 1'b1;
        idle(8, 4'b0000);
        chk("quiet_vld", dst_pulse_vld, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
